// File: rtl/sa_thread_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sa_thread_scheduler: round-robin issue of SA cell-swap pairs to the      |
// | shared cost evaluator. Option macro: SA_SKIP_SELF_PAIR_EN. Rev 1.0       |
// +--------------------------------------------------------------------------+
module sa_thread_scheduler #(
   parameter int N_THREADS = 4,
   parameter int TID_W     = 2,
   parameter int N_CELLS   = 16,
   parameter int CELL_W    = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              done,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [TID_W-1:0]  issue_thread,
   output logic [CELL_W-1:0] issue_ca,
   output logic [CELL_W-1:0] issue_cb,
   input  logic              res_valid,
   input  logic [TID_W-1:0]  res_thread,
   input  logic              res_accept,
   output logic [CNT_W-1:0]  accept_count,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

   localparam logic [CELL_W-1:0] C_CELL_MAX = CELL_W'(N_CELLS - 1);
   localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

   state_t               state_q, state_d;
   logic [TID_W-1:0]     ptr_q, ptr_d;
   logic [CELL_W-1:0]    ca_q [N_THREADS];
   logic [CELL_W-1:0]    ca_d [N_THREADS];
   logic [CELL_W-1:0]    cb_q [N_THREADS];
   logic [CELL_W-1:0]    cb_d [N_THREADS];
   logic [N_THREADS-1:0] out_q, out_d, fin_q, fin_d;
   logic                 vld_q, vld_d;
   logic [TID_W-1:0]     thr_q, thr_d;
   logic [CELL_W-1:0]    ica_q, ica_d, icb_q, icb_d;
   logic [CNT_W-1:0]     acc_q, acc_d;
   logic                 err_q, err_d, done_q, done_d;
   logic [N_THREADS-1:0] elig, skip, adv;
   logic [TID_W-1:0]     cand;
   logic                 found;

   always_comb begin
      skip = '0;
      elig = '0;
      for (int t = 0; t < N_THREADS; t++) begin
`ifdef SA_SKIP_SELF_PAIR_EN
         skip[t] = !fin_q[t] && (ca_q[t] == cb_q[t]);
`else
         skip[t] = 1'b0;
`endif
         elig[t] = !out_q[t] && !fin_q[t] && !skip[t];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ca_d    = ca_q;
      cb_d    = cb_q;
      out_d   = out_q;
      fin_d   = fin_q;
      vld_d   = vld_q;
      thr_d   = thr_q;
      ica_d   = ica_q;
      icb_d   = icb_q;
      acc_d   = acc_q;
      err_d   = err_q;
      adv     = '0;
      cand    = '0;
      found   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               ca_d    = '{default: '0};
               cb_d    = '{default: '0};
               out_d   = '0;
               fin_d   = '0;
               acc_d   = '0;
               err_d   = 1'b0;
               ptr_d   = '0;
               vld_d   = 1'b0;
            end
         end
         S_RUN, S_DRAIN: begin
            if (vld_q && issue_ready)
               vld_d = 1'b0;
            if (res_valid) begin
               if (out_q[res_thread]) begin
                  out_d[res_thread] = 1'b0;
                  if (res_accept && (acc_q != C_CNT_MAX))
                     acc_d = acc_q + 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (state_q == S_RUN) begin
               adv = skip;
               // The issue register is free when empty or being transferred this cycle.
               if (!vld_q || issue_ready) begin
                  for (int i = 0; i < N_THREADS; i++) begin
                     cand = TID_W'((int'(ptr_q) + i) % N_THREADS);
                     if (!found && elig[cand]) begin
                        found       = 1'b1;
                        vld_d       = 1'b1;
                        thr_d       = cand;
                        ica_d       = ca_q[cand];
                        icb_d       = cb_q[cand];
                        out_d[cand] = 1'b1;
                        adv[cand]   = 1'b1;
                        ptr_d       = TID_W'((int'(cand) + 1) % N_THREADS);
                     end
                  end
               end
               if (&fin_q)
                  state_d = S_DRAIN;
            end else if ((out_q == '0) && !vld_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!start)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      for (int t = 0; t < N_THREADS; t++) begin
         if (adv[t]) begin
            if (ca_q[t] == C_CELL_MAX) begin
               ca_d[t] = '0;
               if (cb_q[t] == C_CELL_MAX)
                  fin_d[t] = 1'b1;
               else
                  cb_d[t] = cb_q[t] + 1'b1;
            end else begin
               ca_d[t] = ca_q[t] + 1'b1;
            end
         end
      end
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         ca_q    <= '{default: '0};
         cb_q    <= '{default: '0};
         out_q   <= '0;
         fin_q   <= '0;
         vld_q   <= 1'b0;
         thr_q   <= '0;
         ica_q   <= '0;
         icb_q   <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ca_q    <= ca_d;
         cb_q    <= cb_d;
         out_q   <= out_d;
         fin_q   <= fin_d;
         vld_q   <= vld_d;
         thr_q   <= thr_d;
         ica_q   <= ica_d;
         icb_q   <= icb_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign done         = done_q;
   assign issue_valid  = vld_q;
   assign issue_thread = thr_q;
   assign issue_ca     = ica_q;
   assign issue_cb     = icb_q;
   assign accept_count = acc_q;
   assign err          = err_q;

endmodule
`default_nettype wire

// File: doc/sa_thread_scheduler.md
# sa_thread_scheduler

Issue scheduler for the multi-thread simulated-annealing placer. It generates the candidate cell-swap pairs (ca, cb) for N independent SA threads and issues them, one per cycle, to the shared pipelined cost-evaluation datapath (cell-to-node, neighbourhood, distance, sum reduction, decision). It arbitrates that datapath round-robin, keeps at most one pair outstanding per thread, collects accept/reject results and signals completion.

## Interface
- N_THREADS, 4: number of SA threads sharing the evaluator.
- TID_W, 2: thread-id width, clog2(N_THREADS).
- N_CELLS, 16: cells per placement; the pair counters run 0..N_CELLS-1.
- CELL_W, 4: cell-index width, clog2(N_CELLS).
- CNT_W, 16: accept-counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  level; run request.
- done  out  1  all pairs issued and all results returned.
- issue_valid  out  1  pair on issue bus.
- issue_ready  in  1  evaluator accepts the pair.
- issue_thread  out  TID_W  owning thread.
- issue_ca, issue_cb  out  CELL_W  candidate pair.
- res_valid  in  1  result strobe.
- res_thread  in  TID_W  thread of result.
- res_accept  in  1  swap accepted.
- accept_count  out  CNT_W  total accepted swaps, saturating.
- err  out  1  sticky; result received for a thread with no outstanding pair.

## Operation
- FSM IDLE -> RUN -> DRAIN -> DONE.
  - IDLE: start=1 clears all counters, the scoreboard, accept_count and err, then goes to RUN.
  - RUN: issue pairs. When every thread is finished, go to DRAIN.
  - DRAIN: wait until no pairs are outstanding, then go to DONE.
  - DONE: done=1. start=0 returns to IDLE.
  - start=0 in RUN or DRAIN is ignored; the run completes.
- Per-thread state: ca, cb, outstanding bit, finished bit.
- Pair sequence: start at (0,0). ca increments; at ca=N_CELLS-1, ca wraps to 0 and cb increments. Issuing (N_CELLS-1, N_CELLS-1) sets the thread's finished bit.
- Eligibility: a thread is eligible when it is not outstanding and not finished.
- Round-robin:
  - Search starts at (last granted + 1) mod N_THREADS; the pointer resets to thread 0.
  - The winner's pair is loaded into the issue registers and its outstanding bit is set.
  - The winner's counter advances on the load.
- Handshake:
  - The transfer is issue_valid && issue_ready.
  - While issue_valid && !issue_ready, the payload is held stable and no re-arbitration occurs.
  - After a transfer, the next winner may appear in the following cycle, so back-to-back issues run at 1 per cycle.
- Results:
  - res_valid clears the outstanding bit of res_thread.
  - If res_accept=1, accept_count increments, saturating at all ones.
  - A result for a thread that is not outstanding sets err; the scoreboard and count are unchanged.
- A result arriving in the same cycle as arbitration does not bypass; that thread is eligible from the next cycle.
- Results accepted in IDLE or DONE are ignored; err is not set.

## Timing
- Reset values: done=0, issue_valid=0, issue_thread=0, issue_ca=0, issue_cb=0, accept_count=0, err=0, FSM in IDLE, all counters 0.
- Reset while running aborts immediately. In-flight results after reset are ignored while in IDLE.
- Issue latency:
  - start sampled high in IDLE at edge k puts the FSM in RUN.
  - Arbitration happens at edge k+1.
  - issue_valid is high from edge k+1.
- done rises one cycle after the last outstanding result is received in DRAIN.
- All outputs are registered.

## Configuration
- SA_SKIP_SELF_PAIR_EN:
  - Defined: a thread whose current pair has ca==cb is not eligible. That cycle its counter advances by one without issuing, independent of the grant. If the self pair is (N_CELLS-1, N_CELLS-1), the thread becomes finished. Each thread issues N_CELLS*(N_CELLS-1) pairs.
  - Undefined: all N_CELLS^2 pairs are issued.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 -> all outputs at their reset values; FSM stays IDLE.
- Round-robin (N_THREADS=4, N_CELLS=4, ready=1, results returned 3 cycles after issue, macro undefined) -> first four issues are threads 0,1,2,3 each with (ca,cb)=(0,0). The fifth issue is thread 0 with (1,0), no earlier than its result +1 cycle.
- Backpressure: drop issue_ready for 5 cycles mid-run -> issue_valid stays 1; issue_thread, issue_ca and issue_cb are unchanged for all 5 cycles; no pair is lost or duplicated.
- Full run, all accepted:
  - Macro undefined -> 64 issues, accept_count=64, done=1 after the last result, then back to IDLE on start=0.
  - Macro defined -> 48 issues, accept_count=48, and no issue has ca==cb.
- Spurious result: res_valid for thread 2 while it is not outstanding -> err=1 from the next cycle; accept_count unchanged; the run still completes.
- Reset mid-run after 20 issues -> outputs back to reset values next cycle. A fresh start reissues thread 0 (0,0), and the final accept_count matches the clean-run value.
